// File: rtl/decrypt_fsm.sv
// RC4 keystream generator and decryptor: S-box walk plus XOR with ciphertext, one byte per pass.
// Latency: 9 cycles per byte; DONE follows the last WR_DEC, then one fin_strobe cycle.
// Backpressure: none; memories are assumed to accept a read or write every cycle.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   start                             begin a run (sampled in IDLE only)
//   s_addr, s_wdata, s_wr_en, s_rdata S-box RAM (256x8, read data one cycle after address)
//   enc_addr, enc_rdata               ciphertext ROM (read data one cycle after address)
//   dec_addr, dec_wdata, dec_wr_en    plaintext RAM write port
//   fsm_on, fin_strobe                busy flag, single-cycle completion pulse
module decrypt_fsm #(
  parameter int MSG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [7:0]            s_addr,
  output logic [7:0]            s_wdata,
  output logic                  s_wr_en,
  input  logic [7:0]            s_rdata,
  output logic [MSG_ADDR_W-1:0] enc_addr,
  input  logic [7:0]            enc_rdata,
  output logic [MSG_ADDR_W-1:0] dec_addr,
  output logic [7:0]            dec_wdata,
  output logic                  dec_wr_en,
  output logic                  fsm_on,
  output logic                  fin_strobe
);

  localparam logic [3:0] IDLE         = 4'd0;
  localparam logic [3:0] INC_I        = 4'd1;
  localparam logic [3:0] RD_SI        = 4'd2;
  localparam logic [3:0] STR_SI_J     = 4'd3;
  localparam logic [3:0] RD_SJ        = 4'd4;
  localparam logic [3:0] STR_SJ_WR_SI = 4'd5;
  localparam logic [3:0] WR_SJ        = 4'd6;
  localparam logic [3:0] RD_F         = 4'd7;
  localparam logic [3:0] STR_F        = 4'd8;
  localparam logic [3:0] WR_DEC       = 4'd9;
  localparam logic [3:0] DONE         = 4'd10;

  logic [3:0]            state;
  logic [7:0]            i, j, si, sj, f, e;
  logic [MSG_ADDR_W-1:0] k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i     <= 8'd0;
      j     <= 8'd0;
      si    <= 8'd0;
      sj    <= 8'd0;
      f     <= 8'd0;
      e     <= 8'd0;
      k     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i     <= 8'd0;
            j     <= 8'd0;
            k     <= '0;
            state <= INC_I;
          end
        end
        INC_I: begin
          i     <= i + 8'd1;
          state <= RD_SI;
        end
        RD_SI:    state <= STR_SI_J;
        STR_SI_J: begin
          si    <= s_rdata;
          j     <= j + s_rdata;
          state <= RD_SJ;
        end
        RD_SJ:    state <= STR_SJ_WR_SI;
        // S[j] arrives this cycle while the old S[i] (held in si) is written to j.
        STR_SJ_WR_SI: begin
          sj    <= s_rdata;
          state <= WR_SJ;
        end
        WR_SJ:    state <= RD_F;
        RD_F:     state <= STR_F;
        STR_F: begin
          f     <= s_rdata;
          e     <= enc_rdata;
          state <= WR_DEC;
        end
        WR_DEC: begin
          k     <= k + MSG_ADDR_W'(1);
          state <= (k == '1) ? DONE : INC_I;
        end
        DONE:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Moore output decode: only state and datapath registers feed the outputs.
  always_comb begin
    s_addr     = 8'd0;
    s_wdata    = 8'd0;
    s_wr_en    = 1'b0;
    enc_addr   = '0;
    dec_addr   = '0;
    dec_wdata  = 8'd0;
    dec_wr_en  = 1'b0;
    fin_strobe = 1'b0;
    fsm_on     = 1'b0;
    case (state)
      INC_I:        fsm_on = 1'b1;
      RD_SI: begin
        fsm_on = 1'b1;
        s_addr = i;
      end
      STR_SI_J:     fsm_on = 1'b1;
      RD_SJ: begin
        fsm_on = 1'b1;
        s_addr = j;
      end
      STR_SJ_WR_SI: begin
        fsm_on  = 1'b1;
        s_addr  = j;
        s_wdata = si;
        s_wr_en = 1'b1;
      end
      WR_SJ: begin
        fsm_on  = 1'b1;
        s_addr  = i;
        s_wdata = sj;
        s_wr_en = 1'b1;
      end
      // Sum of the swapped pair is unchanged by the swap, so si+sj indexes f directly.
      RD_F: begin
        fsm_on   = 1'b1;
        s_addr   = si + sj;
        enc_addr = k;
      end
      STR_F:        fsm_on = 1'b1;
      WR_DEC: begin
        fsm_on    = 1'b1;
        dec_addr  = k;
        dec_wdata = f ^ e;
        dec_wr_en = 1'b1;
      end
      DONE:         fin_strobe = 1'b1;
      default: ;
    endcase
  end

endmodule
